data_mem_arbiter: RTL and testbench



---
 rtl/data_mem_arb_pkg.sv | 22 ++
 rtl/data_mem_arb_starve.sv | 32 +++
 rtl/data_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_data_mem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arb_pkg.sv
// Shared types and default sizes for the data memory arbiter.
// Owner tags route registered read data back to the issuing requester.
package data_mem_arb_pkg;

  localparam int ADDR_W_DEF     = 16;
  localparam int DATA_W_DEF     = 16;
  localparam int MEM_DEPTH_DEF  = 512;
  localparam int STARVE_MAX_DEF = 4;
  localparam int LOCK_MAX_DEF   = 16;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_AES
  } owner_t;

  typedef enum logic {
    ARB,
    LOCKED
  } arb_state_t;

endpackage

// File: rtl/data_mem_arb_starve.sv
// Saturating count of consecutive cycles AES was denied.
// at_max_o forces the next AES request to win arbitration.
module data_mem_arb_starve #(
  parameter int MAX = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_max_o
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign at_max_o = (cnt_q == W'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && !at_max_o)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// CPU / AES arbiter for the shared single-port data memory,
// with AES burst lock, lock timeout and starvation guard.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MEM_DEPTH  = MEM_DEPTH_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int LOCK_MAX   = LOCK_MAX_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              aes_req_i,
  input  logic              aes_we_i,
  input  logic [ADDR_W-1:0] aes_addr_i,
  input  logic [DATA_W-1:0] aes_wdata_i,
  input  logic              aes_lock_i,
  output logic              aes_gnt_o,
  output logic              aes_rvalid_o,
  output logic [DATA_W-1:0] aes_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wr_data_o,
  output logic              mem_wr_en_o,
  input  logic [DATA_W-1:0] mem_rd_data_i,
  output logic              err_oob_o,
  output logic              lock_to_o
);

  localparam int LW = $clog2(LOCK_MAX + 1);

  arb_state_t  state_q, state_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic        lock_to_q, lock_to_d;
  owner_t      rd_own_q, rd_own_d;
  logic        rd_oob_q, rd_oob_d;
  logic        err_q, err_d;

  logic              cpu_gnt, aes_gnt, win;
  logic              win_we, inb;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              starve_max, starve_inc;

  assign starve_inc = (state_q == ARB) & aes_req_i & ~aes_gnt;

  data_mem_arb_starve #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clr_i    (~starve_inc),
    .inc_i    (starve_inc),
    .at_max_o (starve_max)
  );

  always_comb begin
    cpu_gnt    = 1'b0;
    aes_gnt    = 1'b0;
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    lock_to_d  = lock_to_q;
    unique case (state_q)
      ARB: begin
        aes_gnt = aes_req_i & (~cpu_req_i | starve_max);
        cpu_gnt = cpu_req_i & ~aes_gnt;
        if (aes_gnt && aes_lock_i) begin
          state_d    = LOCKED;
          lock_cnt_d = '0;
        end
      end
      LOCKED: begin
        aes_gnt    = aes_req_i;
        lock_cnt_d = lock_cnt_q + LW'(1);
        // Dropping lock ends the burst whether or not AES requests.
        if (!aes_lock_i) begin
          state_d = ARB;
        end else if (lock_cnt_q == LW'(LOCK_MAX - 1)) begin
          state_d   = ARB;
          lock_to_d = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    win_we    = 1'b0;
    rd_own_d  = OWN_NONE;
    unique case (1'b1)
      cpu_gnt: begin
        win_addr  = cpu_addr_i;
        win_wdata = cpu_wdata_i;
        win_we    = cpu_we_i;
        rd_own_d  = cpu_we_i ? OWN_NONE : OWN_CPU;
      end
      aes_gnt: begin
        win_addr  = aes_addr_i;
        win_wdata = aes_wdata_i;
        win_we    = aes_we_i;
        rd_own_d  = aes_we_i ? OWN_NONE : OWN_AES;
      end
      default: ;
    endcase
  end

  assign win      = cpu_gnt | aes_gnt;
  assign inb      = {1'b0, win_addr} < (ADDR_W + 1)'(MEM_DEPTH);
  assign rd_oob_d = ~inb;
  assign err_d    = win & ~inb;

  assign cpu_gnt_o     = cpu_gnt;
  assign aes_gnt_o     = aes_gnt;
  assign mem_addr_o    = win_addr;
  assign mem_wr_data_o = win_wdata;
  assign mem_wr_en_o   = win_we & inb;

  assign cpu_rvalid_o = (rd_own_q == OWN_CPU);
  assign aes_rvalid_o = (rd_own_q == OWN_AES);
  assign cpu_rdata_o  = (cpu_rvalid_o && !rd_oob_q) ? mem_rd_data_i : '0;
  assign aes_rdata_o  = (aes_rvalid_o && !rd_oob_q) ? mem_rd_data_i : '0;
  assign err_oob_o    = err_q;
  assign lock_to_o    = lock_to_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ARB;
      lock_cnt_q <= '0;
      lock_to_q  <= 1'b0;
      rd_own_q   <= OWN_NONE;
      rd_oob_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      lock_to_q  <= lock_to_d;
      rd_own_q   <= rd_own_d;
      rd_oob_q   <= rd_oob_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural
// arbitration/memory model checked every cycle.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        aes_req, aes_we, aes_lock, aes_gnt, aes_rvalid;
  logic [15:0] aes_addr, aes_wdata, aes_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rd;
  logic        mem_wr_en, err_oob, lock_to;

  data_mem_arbiter dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .cpu_req_i     (cpu_req),
    .cpu_we_i      (cpu_we),
    .cpu_addr_i    (cpu_addr),
    .cpu_wdata_i   (cpu_wdata),
    .cpu_gnt_o     (cpu_gnt),
    .cpu_rvalid_o  (cpu_rvalid),
    .cpu_rdata_o   (cpu_rdata),
    .aes_req_i     (aes_req),
    .aes_we_i      (aes_we),
    .aes_addr_i    (aes_addr),
    .aes_wdata_i   (aes_wdata),
    .aes_lock_i    (aes_lock),
    .aes_gnt_o     (aes_gnt),
    .aes_rvalid_o  (aes_rvalid),
    .aes_rdata_o   (aes_rdata),
    .mem_addr_o    (mem_addr),
    .mem_wr_data_o (mem_wdata),
    .mem_wr_en_o   (mem_wr_en),
    .mem_rd_data_i (mem_rd),
    .err_oob_o     (err_oob),
    .lock_to_o     (lock_to)
  );

  always #5 clk = ~clk;

  logic [15:0] env_mem [512];
  logic [15:0] model_mem [512];
  logic [15:0] rd_q = 16'h0;
  assign mem_rd = rd_q;

  // registered, read-first single-port memory
  always @(posedge clk) begin
    rd_q <= env_mem[mem_addr[8:0]];
    if (mem_wr_en) env_mem[mem_addr[8:0]] = mem_wdata;
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
  endtask

  int          m_denied;
  bit          m_locked;
  int          m_beats;
  bit          m_lockto;
  int          m_own;
  logic [15:0] m_data;
  bit          m_err;

  always @(negedge clk) begin : model
    bit cw, aw, we, hit;
    logic [15:0] a, d;
    if (!rst_n) begin
      m_denied = 0; m_locked = 0; m_beats = 0;
      m_lockto = 0; m_own = 0; m_data = 0; m_err = 0;
      chk("rst_cpu_gnt", 32'(cpu_gnt), 0);
      chk("rst_aes_gnt", 32'(aes_gnt), 0);
      chk("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
      chk("rst_aes_rvalid", 32'(aes_rvalid), 0);
      chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
      chk("rst_aes_rdata", 32'(aes_rdata), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_wr_en", 32'(mem_wr_en), 0);
      chk("rst_err_oob", 32'(err_oob), 0);
      chk("rst_lock_to", 32'(lock_to), 0);
    end else begin
      if (!m_locked) begin
        aw = aes_req && (!cpu_req || m_denied >= 4);
        cw = cpu_req && !aw;
      end else begin
        aw = aes_req;
        cw = 0;
      end
      a   = cw ? cpu_addr  : aw ? aes_addr  : 16'h0;
      d   = cw ? cpu_wdata : aw ? aes_wdata : 16'h0;
      we  = cw ? cpu_we    : aw ? aes_we    : 1'b0;
      hit = (cw || aw) && (a < 16'd512);
      chk("cpu_gnt", 32'(cpu_gnt), 32'(cw));
      chk("aes_gnt", 32'(aes_gnt), 32'(aw));
      chk("mem_addr", 32'(mem_addr), 32'(a));
      chk("mem_wdata", 32'(mem_wdata), 32'(d));
      chk("mem_wr_en", 32'(mem_wr_en), 32'(hit && we));
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_own == 1));
      chk("aes_rvalid", 32'(aes_rvalid), 32'(m_own == 2));
      chk("cpu_rdata", 32'(cpu_rdata), 32'(m_own == 1 ? m_data : 16'h0));
      chk("aes_rdata", 32'(aes_rdata), 32'(m_own == 2 ? m_data : 16'h0));
      chk("err_oob", 32'(err_oob), 32'(m_err));
      chk("lock_to", 32'(lock_to), 32'(m_lockto));
      // advance to the state seen after the coming edge
      m_denied = (!m_locked && aes_req && !aw) ?
                 (m_denied < 4 ? m_denied + 1 : 4) : 0;
      if (!m_locked) begin
        if (aw && aes_lock) begin
          m_locked = 1;
          m_beats  = 0;
        end
      end else begin
        m_beats++;
        if (!aes_lock) m_locked = 0;
        else if (m_beats == 16) begin
          m_locked = 0;
          m_lockto = 1;
        end
      end
      m_own  = ((cw || aw) && !we) ? (cw ? 1 : 2) : 0;
      m_data = hit ? model_mem[a[8:0]] : 16'h0;
      m_err  = (cw || aw) && !hit;
      if (hit && we) model_mem[a[8:0]] = d;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nchk();
    @(negedge clk);
    #1;
  endtask

  task automatic cpu(input logic r, input logic w,
                     input logic [15:0] a, input logic [15:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic aes(input logic r, input logic w, input logic [15:0] a,
                     input logic [15:0] d, input logic l);
    aes_req = r; aes_we = w; aes_addr = a; aes_wdata = d; aes_lock = l;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 512; i++) begin
      env_mem[i]   = 16'(i) ^ 16'h5A00;
      model_mem[i] = 16'(i) ^ 16'h5A00;
    end
    cpu(0, 0, 16'h0, 16'h0);
    aes(0, 0, 16'h0, 16'h0, 0);
    #1 rst_n = 1'b0;
    repeat (2) tick();
    nchk();
    chk("reset_wr_en", 32'(mem_wr_en), 0);
    chk("reset_lock_to", 32'(lock_to), 0);
    tick();
    rst_n = 1'b1;
    nchk();
    chk("idle_gnt", 32'({cpu_gnt, aes_gnt}), 0);
    tick();

    // CPU write then read back
    cpu(1, 1, 16'h0010, 16'hBEEF);
    nchk();
    chk("wr_gnt", 32'(cpu_gnt), 1);
    chk("wr_en", 32'(mem_wr_en), 1);
    tick();
    cpu(1, 0, 16'h0010, 16'h0);
    nchk();
    chk("rd_gnt", 32'(cpu_gnt), 1);
    chk("rd_no_wr", 32'(mem_wr_en), 0);
    tick();
    cpu(0, 0, 16'h0, 16'h0);
    nchk();
    chk("rd_rvalid", 32'(cpu_rvalid), 1);
    chk("rd_data", 32'(cpu_rdata), 32'hBEEF);
    chk("rd_aes_rvalid", 32'(aes_rvalid), 0);
    tick();

    // contention: four CPU wins, then AES
    cpu(1, 0, 16'h0020, 16'h0);
    aes(1, 0, 16'h0030, 16'h0, 0);
    for (int i = 0; i < 10; i++) begin
      nchk();
      chk("rr_aes_gnt", 32'(aes_gnt), (i % 5 == 4) ? 1 : 0);
      chk("rr_cpu_gnt", 32'(cpu_gnt), (i % 5 == 4) ? 0 : 1);
      tick();
    end
    cpu(0, 0, 16'h0, 16'h0);
    aes(0, 0, 16'h0, 16'h0, 0);
    nchk();
    tick();

    // locked 8-beat AES read burst with CPU requesting
    cpu(1, 0, 16'h0040, 16'h0);
    for (int c = 0; c < 13; c++) begin
      int beat;
      beat = (c < 4) ? 0 : c - 4;
      if (c < 12) aes(1, 0, 16'(16'h0100 + beat), 16'h0, beat < 7);
      else        aes(0, 0, 16'h0, 16'h0, 0);
      nchk();
      if (c < 4) begin
        chk("bu_pre_cpu", 32'(cpu_gnt), 1);
        chk("bu_pre_aes", 32'(aes_gnt), 0);
      end else if (c < 12) begin
        chk("bu_aes_gnt", 32'(aes_gnt), 1);
        chk("bu_cpu_blk", 32'(cpu_gnt), 0);
      end else begin
        chk("bu_cpu_after", 32'(cpu_gnt), 1);
        chk("bu_last_data", 32'(aes_rdata), 32'h5B07);
      end
      if (c >= 5) chk("bu_rvalid", 32'(aes_rvalid), 1);
      tick();
    end
    cpu(0, 0, 16'h0, 16'h0);
    nchk();
    tick();

    // lock held too long
    for (int c = 0; c < 21; c++) begin
      if (c < 20) aes(1, 0, 16'h0080, 16'h0, 1);
      else        aes(0, 0, 16'h0, 16'h0, 0);
      cpu(c >= 1, 0, 16'h0050, 16'h0);
      nchk();
      if (c >= 1 && c <= 16) begin
        chk("to_cpu_blk", 32'(cpu_gnt), 0);
        chk("to_aes_gnt", 32'(aes_gnt), 1);
        chk("to_not_yet", 32'(lock_to), 0);
      end
      if (c == 17) begin
        chk("to_cpu_gnt", 32'(cpu_gnt), 1);
        chk("to_flag", 32'(lock_to), 1);
      end
      if (c == 20) chk("to_sticky", 32'(lock_to), 1);
      tick();
    end
    cpu(0, 0, 16'h0, 16'h0);
    nchk();
    tick();

    // out-of-bounds read and write
    cpu(1, 0, 16'h0200, 16'h0);
    nchk();
    chk("oob_rd_gnt", 32'(cpu_gnt), 1);
    tick();
    cpu(1, 1, 16'h0200, 16'h1234);
    nchk();
    chk("oob_err_rd", 32'(err_oob), 1);
    chk("oob_rvalid", 32'(cpu_rvalid), 1);
    chk("oob_rdata", 32'(cpu_rdata), 0);
    chk("oob_wr_gnt", 32'(cpu_gnt), 1);
    chk("oob_wr_en", 32'(mem_wr_en), 0);
    tick();
    cpu(1, 0, 16'h0000, 16'h0);
    nchk();
    chk("oob_err_wr", 32'(err_oob), 1);
    chk("oob_wr_norsp", 32'(cpu_rvalid), 0);
    tick();
    cpu(0, 0, 16'h0, 16'h0);
    nchk();
    chk("oob_no_alias", 32'(cpu_rdata), 32'h5A00);
    chk("oob_err_clr", 32'(err_oob), 0);
    tick();

    // reset in the middle of a locked burst
    aes(1, 0, 16'h0100, 16'h0, 1);
    nchk();
    chk("rl_gnt0", 32'(aes_gnt), 1);
    tick();
    aes(1, 0, 16'h0101, 16'h0, 1);
    nchk();
    chk("rl_gnt1", 32'(aes_gnt), 1);
    tick();
    aes(0, 0, 16'h0, 16'h0, 0);
    rst_n = 1'b0;
    nchk();
    chk("rl_drop", 32'(aes_rvalid), 0);
    chk("rl_lock_to", 32'(lock_to), 0);
    tick();
    nchk();
    tick();
    rst_n = 1'b1;
    cpu(1, 0, 16'h0010, 16'h0);
    aes(1, 0, 16'h0102, 16'h0, 1);
    nchk();
    chk("rl_arb_cpu", 32'(cpu_gnt), 1);
    chk("rl_arb_aes", 32'(aes_gnt), 0);
    chk("rl_no_rvalid", 32'(aes_rvalid), 0);
    tick();
    cpu(0, 0, 16'h0, 16'h0);
    aes(0, 0, 16'h0, 16'h0, 0);
    nchk();
    chk("rl_cpu_data", 32'(cpu_rdata), 32'hBEEF);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
